// File: rtl/rv_ibuf_pkg.sv
// rtl/rv_ibuf_pkg.sv - shared FSM type and address-geometry helpers for the instruction line buffer
package rv_ibuf_pkg;

    // Refill controller states: waiting for a miss, or streaming a line in.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // Word-offset bits within a line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index bits; zero when the buffer holds a single line.
    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag bits: everything above the byte, offset and index fields.
    function automatic int tag_bits(input int line_words, input int num_lines);
        return 30 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/rv_ibuf_fill.sv
// rtl/rv_ibuf_fill.sv - line refill sequencer driving the backing request/acknowledge bus
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   start_i         begin a refill of the line at base_i (honoured only when idle)
//   base_i          byte address of the line's first word
//   busy_o          a refill is in progress
//   mem_req_o       backing read request, held until the last word is acknowledged
//   mem_addr_o      byte address of the word currently requested
//   mem_data_i      backing read data, qualified by mem_ack_i
//   mem_ack_i       backing read completes this cycle
//   wr_en_o         write mem_data_i into the line at word wr_off_o
//   wr_off_o        word offset being written
//   wr_data_o       word being written
//   done_o          last word of the line is being written this cycle
module rv_ibuf_fill
    import rv_ibuf_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    localparam int OW = off_bits(LINE_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   base_i,
    output logic          busy_o,
    output logic          mem_req_o,
    output logic [31:0]   mem_addr_o,
    input  logic [31:0]   mem_data_i,
    input  logic          mem_ack_i,
    output logic          wr_en_o,
    output logic [OW-1:0] wr_off_o,
    output logic [31:0]   wr_data_o,
    output logic          done_o
);

    fill_state_e   state_q;
    fill_state_e   state_d;
    logic [OW-1:0] k_q;
    logic [31:0]   addr_q;
    logic          last_word;
    logic          word_ack;

    assign last_word = (k_q == OW'(LINE_WORDS - 1));
    assign word_ack  = (state_q == ST_FILL) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_FILL;
            ST_FILL: if (mem_ack_i && last_word) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The request address advances on the same edge that accepts the
    // previous word, so an ack held high streams one word per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q    <= '0;
            addr_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            k_q    <= '0;
            addr_q <= base_i;
        end else if (word_ack) begin
            k_q    <= k_q + 1'b1;
            addr_q <= addr_q + 32'd4;
        end
    end

    assign busy_o     = (state_q == ST_FILL);
    assign mem_req_o  = (state_q == ST_FILL);
    assign mem_addr_o = addr_q;
    assign wr_en_o    = word_ack;
    assign wr_off_o   = k_q;
    assign wr_data_o  = mem_data_i;
    assign done_o     = word_ack && last_word;

endmodule

// File: rtl/rv_ibuf.sv
// rtl/rv_ibuf.sv - direct-mapped instruction line buffer serving the fetch port
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   im_addr_i       fetch byte address, looked up every cycle (bits [1:0] ignored)
//   im_data_o       word for the address sampled on the previous edge
//   im_valid_o      im_data_o is valid for the address sampled on the previous edge
//   flush_i         one-cycle pulse invalidating every line
//   mem_req_o       backing read request
//   mem_addr_o      backing word byte-address
//   mem_data_i      backing read data
//   mem_ack_i       backing read completes this cycle
module rv_ibuf
    import rv_ibuf_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int OW   = off_bits(LINE_WORDS);
    localparam int IW   = idx_bits(NUM_LINES);
    localparam int TW   = tag_bits(LINE_WORDS, NUM_LINES);
    localparam int IW_S = (IW == 0) ? 1 : IW;

    logic [OW-1:0]   off;
    logic [IW_S-1:0] idx;
    logic [TW-1:0]   tag;
    logic [31:0]     line_base;
    logic            addr_lsb_unused;

    assign off             = im_addr_i[OW+1:2];
    assign tag             = im_addr_i[31 -: TW];
    assign line_base       = {im_addr_i[31:OW+2], {(OW + 2){1'b0}}};
    assign addr_lsb_unused = ^im_addr_i[1:0];

    if (IW == 0) begin : g_single_line
        assign idx = '0;
    end else begin : g_multi_line
        assign idx = im_addr_i[OW+2 +: IW_S];
    end

    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
    logic [IW_S-1:0]      fill_idx_q;
    logic                 poison_q;

    logic          hit;
    logic          start;
    logic          fill_busy;
    logic          wr_en;
    logic [OW-1:0] wr_off;
    logic [31:0]   wr_data;
    logic          line_done;

    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    // Only one refill at a time; misses seen while busy are dropped and
    // come back through the fetch unit re-presenting the address.
    assign start = !fill_busy && !hit;

    rv_ibuf_fill #(
        .LINE_WORDS (LINE_WORDS)
    ) u_fill (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start),
        .base_i     (line_base),
        .busy_o     (fill_busy),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .wr_en_o    (wr_en),
        .wr_off_o   (wr_off),
        .wr_data_o  (wr_data),
        .done_o     (line_done)
    );

    // Valid bits. The line being refilled is invalid for the whole burst.
    // A flush seen at any point during the burst (including the edge of the
    // final word) poisons it so the line is never marked valid with words
    // that may predate the fence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            fill_idx_q <= '0;
            poison_q   <= 1'b0;
        end else begin
            if (start) begin
                valid_q[idx] <= 1'b0;
                fill_idx_q   <= idx;
                poison_q     <= 1'b0;
            end else if (flush_i && fill_busy) begin
                poison_q <= 1'b1;
            end
            if (line_done && !poison_q && !flush_i) begin
                valid_q[fill_idx_q] <= 1'b1;
            end
            if (flush_i) begin
                valid_q <= '0;
            end
        end
    end

    // Tag and data storage need no reset: nothing reads them without a valid bit.
    always_ff @(posedge clk_i) begin
        if (start) begin
            tag_q[idx] <= tag;
        end
        if (wr_en) begin
            data_q[fill_idx_q][wr_off] <= wr_data;
        end
    end

    // Registered fetch response; data holds on a miss or during a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            im_valid_o <= 1'b0;
            im_data_o  <= '0;
        end else begin
            im_valid_o <= hit && !flush_i;
            if (hit && !flush_i) begin
                im_data_o <= data_q[idx][off];
            end
        end
    end

endmodule

// File: tb/tb_rv_ibuf.sv
// tb/tb_rv_ibuf.sv - self-checking bench for rv_ibuf
module tb_rv_ibuf;

    localparam int          LW         = 4;
    // Eight lines so 0x40 and 0x100 land in different sets.
    localparam int          NL         = 8;
    localparam int          LINE_BYTES = LW * 4;
    localparam logic [31:0] K          = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    rv_ibuf #(
        .LINE_WORDS (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .im_addr_i  (im_addr_i),
        .im_data_o  (im_data_o),
        .im_valid_o (im_valid_o),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    // Backing-bus responder state.
    int          ack_lat  = 0;
    bit          rand_lat = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] ack_log[$];

    // Reference model: set of fully fetched line bases plus the refill in flight.
    logic [31:0] resident[$];
    bit          m_fill   = 1'b0;
    logic [31:0] m_base   = '0;
    int          m_k      = 0;
    bit          m_poison = 1'b0;
    logic [31:0] m_data   = '0;

    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_req;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic int set_of(input logic [31:0] b);
        return int'((b / LINE_BYTES) % NL);
    endfunction

    function automatic bit is_resident(input logic [31:0] b);
        foreach (resident[i]) if (resident[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic evict_set(input int s);
        for (int i = resident.size() - 1; i >= 0; i--) begin
            if (set_of(resident[i]) == s) resident.delete(i);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 31)) << 4) | 32'($urandom_range(0, 15));
    endfunction

    // One clock: answer the bus, predict the edge, advance, then check.
    task automatic step();
        logic [31:0] a;
        logic [31:0] b;
        bit          p_hit;
        bit          p_valid;
        bit          was_fill;
        bit          acking;
        bit          req_before;

        req_before = (mem_req_o === 1'b1);
        acking     = 1'b0;
        if (req_before && wait_cnt >= ack_lat) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_addr_o ^ K;
            ack_log.push_back(mem_addr_o);
            acking     = 1'b1;
        end else begin
            mem_ack_i  = 1'b0;
            mem_data_i = $urandom;
        end

        a       = im_addr_i & ~32'h3;
        b       = a & ~32'(LINE_BYTES - 1);
        p_hit   = is_resident(b);
        p_valid = p_hit && !flush_i && !rst_i;

        if (rst_i) begin
            resident.delete();
            m_fill   = 1'b0;
            m_k      = 0;
            m_poison = 1'b0;
            m_data   = '0;
        end else begin
            was_fill = m_fill;
            if (m_fill) begin
                if (acking) begin
                    m_k++;
                    if (m_k == LW) begin
                        m_fill = 1'b0;
                        if (!m_poison && !flush_i) resident.push_back(m_base);
                    end
                end
            end else if (!p_hit) begin
                evict_set(set_of(b));
                m_fill   = 1'b1;
                m_base   = b;
                m_k      = 0;
                m_poison = 1'b0;
            end
            if (flush_i) begin
                resident.delete();
                if (was_fill) m_poison = 1'b1;
            end
            if (p_valid) m_data = a ^ K;
        end

        @(posedge clk);
        @(negedge clk);

        if (acking) begin
            wait_cnt = 0;
            if (rand_lat) ack_lat = $urandom_range(0, 2);
        end else if (req_before) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end

        chk("model_valid", 32'(im_valid_o), 32'(p_valid));
        chk("model_data", im_data_o, m_data);
        chk("model_req", 32'(mem_req_o), 32'(m_fill));
        if (m_fill) chk("model_mem_addr", mem_addr_o, m_base + 32'(m_k * 4));
    endtask

    task automatic run_until_valid(input string name, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (im_valid_o !== 1'b1 && n < limit);
        chk({name, "_reached"}, 32'(im_valid_o), 32'd1);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < ack_log.size()) ? ack_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int          n;
        bit          saw_final;
        logic [31:0] exp_br[8];

        rst_i      = 1'b1;
        flush_i    = 1'b0;
        im_addr_i  = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;

        // Reset state.
        step();
        step();
        chk("rst_valid", 32'(im_valid_o), 32'd0);
        chk("rst_data", im_data_o, 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);

        // First fill of line 0x0 at one wait cycle per word.
        rst_i   = 1'b0;
        ack_lat = 1;
        ack_log.delete();
        run_until_valid("fill0", 40, n);
        chk("fill0_latency", 32'(n), 32'(2 + LW * 2));
        chk("fill0_words", 32'(ack_log.size()), 32'(LW));
        for (int i = 0; i < LW; i++) chk("fill0_addr", log_at(i), 32'(i * 4));
        chk("fill0_data", im_data_o, K);

        // Back-to-back hits, then a flush and the miss that follows it.
        vecs[0] = '{32'h0, 1'b0, 1'b1, K,            1'b0};
        vecs[1] = '{32'h4, 1'b0, 1'b1, K ^ 32'h4,    1'b0};
        vecs[2] = '{32'h8, 1'b0, 1'b1, K ^ 32'h8,    1'b0};
        vecs[3] = '{32'hC, 1'b0, 1'b1, K ^ 32'hC,    1'b0};
        vecs[4] = '{32'h0, 1'b1, 1'b0, K ^ 32'hC,    1'b0};
        vecs[5] = '{32'h0, 1'b0, 1'b0, K ^ 32'hC,    1'b1};
        ack_log.delete();
        for (int i = 0; i < 6; i++) begin
            im_addr_i = vecs[i].addr;
            flush_i   = vecs[i].flush;
            step();
            flush_i   = 1'b0;
            chk("tbl_valid", 32'(im_valid_o), 32'(vecs[i].exp_valid));
            chk("tbl_data", im_data_o, vecs[i].exp_data);
            chk("tbl_req", 32'(mem_req_o), 32'(vecs[i].exp_req));
        end
        run_until_valid("refill0", 40, n);
        chk("refill0_first", log_at(0), 32'h0);
        chk("refill0_data", im_data_o, K);

        // Branch away from 0x40 after its first ack: both lines fill in order.
        ack_log.delete();
        im_addr_i = 32'h40;
        for (int i = 0; i < 20 && ack_log.size() == 0; i++) step();
        chk("br_first_ack", 32'(ack_log.size()), 32'd1);
        im_addr_i = 32'h100;
        run_until_valid("br", 80, n);
        exp_br = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h100, 32'h104, 32'h108, 32'h10C};
        chk("br_words", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("br_addr", log_at(i), exp_br[i]);
        chk("br_data", im_data_o, 32'h100 ^ K);
        im_addr_i = 32'h40;
        step();
        chk("br_return_valid", 32'(im_valid_o), 32'd1);
        chk("br_return_data", im_data_o, 32'h40 ^ K);
        chk("br_return_req", 32'(mem_req_o), 32'd0);

        // Flush coincident with the final ack of line 0x20 (zero-wait acks).
        ack_lat   = 0;
        saw_final = 1'b0;
        im_addr_i = 32'h20;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_o === 1'b1 && mem_addr_o === 32'h2C) begin
                flush_i = 1'b1;
                step();
                flush_i   = 1'b0;
                saw_final = 1'b1;
                break;
            end
            step();
        end
        chk("fl_final_seen", 32'(saw_final), 32'd1);
        chk("fl_valid", 32'(im_valid_o), 32'd0);
        chk("fl_req_done", 32'(mem_req_o), 32'd0);
        step();
        chk("fl_retry_req", 32'(mem_req_o), 32'd1);
        chk("fl_retry_addr", mem_addr_o, 32'h20);

        // Reset in the middle of that refill.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_mid_req", 32'(mem_req_o), 32'd0);
        chk("rst_mid_valid", 32'(im_valid_o), 32'd0);
        im_addr_i = 32'h40;
        step();
        chk("rst_miss_valid", 32'(im_valid_o), 32'd0);
        chk("rst_miss_req", 32'(mem_req_o), 32'd1);
        chk("rst_miss_addr", mem_addr_o, 32'h40);
        run_until_valid("rst_refill", 40, n);

        // Randomised fetch stream, branches, flushes, resets and bus latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (im_valid_o === 1'b1) begin
                im_addr_i = ($urandom_range(0, 3) == 0) ? rand_addr() : im_addr_i + 32'd4;
            end else if ($urandom_range(0, 19) == 0) begin
                im_addr_i = rand_addr();
            end
            flush_i = ($urandom_range(0, 31) == 0);
            rst_i   = ($urandom_range(0, 255) == 0);
            step();
        end
        flush_i = 1'b0;
        rst_i   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
